// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared op encodings, stage states and op-class helpers
package mem_wb_stage_pkg;

    typedef enum logic [2:0] {
        CMD_ADD = 3'b000,
        CMD_AND = 3'b001,
        CMD_XOR = 3'b010,
        CMD_BEQ = 3'b011,
        CMD_MOV = 3'b100,
        CMD_LD  = 3'b101,
        CMD_ST  = 3'b110,
        CMD_RTL = 3'b111
    } alu_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MEM_RD = 2'd1,
        ST_MEM_WR = 2'd2,
        ST_LD_WB  = 2'd3
    } mws_state_t;

    function automatic logic is_alu(input alu_cmd_t cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_AND) || (cmd == CMD_XOR) || (cmd == CMD_RTL);
    endfunction

    function automatic logic writes_rf(input alu_cmd_t cmd);
        return is_alu(cmd) || (cmd == CMD_MOV);
    endfunction

    function automatic logic updates_zp(input alu_cmd_t cmd);
        return is_alu(cmd) || (cmd == CMD_BEQ);
    endfunction

    function automatic logic updates_sc(input alu_cmd_t cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_RTL);
    endfunction

endpackage

// File: rtl/mem_wb_stage_mem_access_fsm.sv
// rtl/mem_wb_stage_mem_access_fsm.sv - data-memory req/ack handshake with timeout abort
module mem_access_fsm
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_ld,
    input  logic       start_st,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic       in_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       err,
    output logic       ld_wb,
    output logic [7:0] rd_data
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mws_state_t       state;
    logic [CNT_W-1:0] cnt;

    assign ld_wb = (state == ST_LD_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 8'h00;
            mem_wdata <= 8'h00;
            err       <= 1'b0;
            rd_data   <= 8'h00;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ld || start_st) begin
                        state     <= start_ld ? ST_MEM_RD : ST_MEM_WR;
                        in_ready  <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_we    <= start_st;
                        mem_addr  <= addr;
                        mem_wdata <= wdata;
                        cnt       <= '0;
                    end
                end
                ST_MEM_RD, ST_MEM_WR: begin
                    // An ack arriving on the final wait cycle still completes normally.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (state == ST_MEM_RD) begin
                            rd_data <= mem_rdata;
                            state   <= ST_LD_WB;
                        end else begin
                            state    <= ST_IDLE;
                            in_ready <= 1'b1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        mem_req  <= 1'b0;
                        err      <= 1'b1;
                        state    <= ST_IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_LD_WB: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                    mem_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory access, register writeback and flag registers behind the ALU
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int RA_W    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      alu_cmd,
    input  logic [7:0]      rslt,
    input  logic [7:0]      st_data,
    input  logic [RA_W-1:0] dst,
    input  logic            sc_o,
    input  logic            zero,
    input  logic            pari,
    output logic            mem_req,
    output logic            mem_we,
    output logic [7:0]      mem_addr,
    output logic [7:0]      mem_wdata,
    input  logic [7:0]      mem_rdata,
    input  logic            mem_ack,
    output logic            rf_we,
    output logic [RA_W-1:0] rf_waddr,
    output logic [7:0]      rf_wdata,
    output logic            sc_q,
    output logic            zero_q,
    output logic            pari_q,
    output logic            err
);

    alu_cmd_t        cmd;
    logic            accept;
    logic            ld_wb;
    logic [7:0]      rd_data;
    logic [RA_W-1:0] ld_dst;

    assign cmd    = alu_cmd_t'(alu_cmd);
    assign accept = in_valid && in_ready;

    mem_access_fsm #(.TIMEOUT(TIMEOUT)) u_mem_access_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_ld  (accept && (cmd == CMD_LD)),
        .start_st  (accept && (cmd == CMD_ST)),
        .addr      (rslt),
        .wdata     (st_data),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .in_ready  (in_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .err       (err),
        .ld_wb     (ld_wb),
        .rd_data   (rd_data)
    );

    // in_ready is low during LD_WB, so a new accept never collides with load writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= 8'h00;
            ld_dst   <= '0;
            sc_q     <= 1'b0;
            zero_q   <= 1'b0;
            pari_q   <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            if (accept && writes_rf(cmd)) begin
                rf_we    <= 1'b1;
                rf_waddr <= dst;
                rf_wdata <= rslt;
            end else if (ld_wb) begin
                rf_we    <= 1'b1;
                rf_waddr <= ld_dst;
                rf_wdata <= rd_data;
            end
            if (accept && (cmd == CMD_LD)) begin
                ld_dst <= dst;
            end
            if (accept && updates_zp(cmd)) begin
                zero_q <= zero;
                pari_q <= pari;
            end
            if (accept && updates_sc(cmd)) begin
                sc_q <= sc_o;
            end
        end
    end

endmodule
